// File: rtl/pifo_client_if.sv
// Client-side handshakes of pifo_client: enqueue request channel and dequeue result channel.
interface pifo_client_if #(
  parameter int RANK_WIDTH = 10,
  parameter int META_WIDTH = 20
);
  logic                  enq_valid;
  logic                  enq_ready;
  logic [RANK_WIDTH-1:0] enq_rank;
  logic [META_WIDTH-1:0] enq_meta;
  logic                  deq_valid;
  logic                  deq_ready;
  logic [RANK_WIDTH-1:0] deq_rank;
  logic [META_WIDTH-1:0] deq_meta;

  modport master (
    output enq_valid, enq_rank, enq_meta, deq_ready,
    input  enq_ready, deq_valid, deq_rank, deq_meta
  );

  modport slave (
    input  enq_valid, enq_rank, enq_meta, deq_ready,
    output enq_ready, deq_valid, deq_rank, deq_meta
  );
endinterface

// File: rtl/pifo_client.sv
// Initiator front end for the skip-list PIFO: gated insert path, paced autonomous
// removal into a small output FIFO, occupancy tracking and underflow flag.
module pifo_client #(
  parameter int RANK_WIDTH     = 10,
  parameter int META_WIDTH     = 20,
  parameter int MAX_ENTRIES    = 160,
  parameter int L2_MAX_ENTRIES = 8,
  parameter int REMOVE_GAP     = 2,
  parameter int OUT_DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  pifo_client_if.slave              cli,
  input  logic                      deq_en,
  output logic                      pifo_insert,
  output logic [RANK_WIDTH-1:0]     pifo_rank_in,
  output logic [META_WIDTH-1:0]     pifo_meta_in,
  output logic                      pifo_remove,
  input  logic [RANK_WIDTH-1:0]     pifo_rank_out,
  input  logic [META_WIDTH-1:0]     pifo_meta_out,
  input  logic                      pifo_valid_out,
  input  logic                      pifo_busy,
  output logic [L2_MAX_ENTRIES-1:0] occupancy,
  output logic                      err_underflow
);

  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = $clog2(REMOVE_GAP) + 1;

  typedef enum logic {D_IDLE, D_GAP} dstate_t;

  dstate_t               state, state_n;
  logic [GW-1:0]         gap_cnt, gap_cnt_n;

  logic [RANK_WIDTH-1:0] rank_mem [OUT_DEPTH];
  logic [META_WIDTH-1:0] meta_mem [OUT_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         free;

  logic                  enq_ok;
  logic                  ins;
  logic                  pop;
  logic                  fire;

  // Enqueue path is purely combinational so an accepted request reaches the PIFO same cycle.
  always_comb begin
    enq_ok       = !rst && !pifo_busy && (occupancy < L2_MAX_ENTRIES'(MAX_ENTRIES));
    ins          = cli.enq_valid && enq_ok;
    cli.enq_ready = enq_ok;
    pifo_insert  = ins;
    pifo_rank_in = ins ? cli.enq_rank : '0;
    pifo_meta_in = ins ? cli.enq_meta : '0;
  end

  // A pop in the same cycle frees a slot, letting a full FIFO accept the next remove.
  always_comb begin
    pop  = (count != '0) && cli.deq_ready;
    free = CW'(OUT_DEPTH) - count + {{(CW-1){1'b0}}, pop};
    fire = !rst && (state == D_IDLE) && deq_en && pifo_valid_out && (free != '0);
  end

  always_comb begin
    cli.deq_valid = (count != '0);
    cli.deq_rank  = rank_mem[rd_ptr];
    cli.deq_meta  = meta_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= D_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    gap_cnt_n   = gap_cnt;
    pifo_remove = 1'b0;
    case (state)
      D_IDLE: begin
        if (fire) begin
          pifo_remove = 1'b1;
          state_n     = D_GAP;
          gap_cnt_n   = GW'(REMOVE_GAP - 1);
        end
      end
      D_GAP: begin
        if (gap_cnt == '0) begin
          state_n = D_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - 1'b1;
        end
      end
      default: state_n = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        rank_mem[i] <= '0;
        meta_mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire) begin
        rank_mem[wr_ptr] <= pifo_rank_out;
        meta_mem[wr_ptr] <= pifo_meta_out;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy     <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pifo_remove && (occupancy == '0)) begin
        err_underflow <= 1'b1;
      end
      case ({ins, pifo_remove})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= (occupancy == '0) ? occupancy : occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_pifo_client.sv
// Directed bench for pifo_client: table of enqueue-path vectors plus hand-written
// sequences for capacity, remove pacing, output backpressure and underflow.
module tb_pifo_client;
  logic        clk = 1'b0;
  logic        rst;
  logic        deq_en;
  logic        pifo_insert, pifo_remove, pifo_valid_out, pifo_busy;
  logic [9:0]  pifo_rank_in, pifo_rank_out;
  logic [19:0] pifo_meta_in, pifo_meta_out;
  logic [7:0]  occupancy;
  logic        err_underflow;

  int n_cmp = 0;
  int n_fail = 0;

  pifo_client_if #(.RANK_WIDTH(10), .META_WIDTH(20)) cli_if ();

  pifo_client #(
    .RANK_WIDTH(10), .META_WIDTH(20), .MAX_ENTRIES(160),
    .L2_MAX_ENTRIES(8), .REMOVE_GAP(2), .OUT_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .cli(cli_if), .deq_en(deq_en),
    .pifo_insert(pifo_insert), .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
    .pifo_remove(pifo_remove), .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out),
    .pifo_valid_out(pifo_valid_out), .pifo_busy(pifo_busy),
    .occupancy(occupancy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic        busy;
    logic        pvo;
    logic [9:0]  rank;
    logic [19:0] meta;
    logic        e_ready;
    logic        e_ins;
    logic [9:0]  e_rank;
    logic [19:0] e_meta;
    logic [7:0]  e_occ;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : main
    int k;
    logic exp_rem, exp_dv;
    logic [9:0] ranks [3];

    vt[0] = '{1'b1, 1'b0, 1'b0, 10'd5,   20'h0000A, 1'b1, 1'b1, 10'd5,   20'h0000A, 8'd1};
    vt[1] = '{1'b1, 1'b1, 1'b0, 10'd6,   20'h00123, 1'b0, 1'b0, 10'd0,   20'h00000, 8'd1};
    vt[2] = '{1'b1, 1'b0, 1'b0, 10'd6,   20'h00123, 1'b1, 1'b1, 10'd6,   20'h00123, 8'd2};
    vt[3] = '{1'b0, 1'b0, 1'b0, 10'h3FF, 20'hFFFFF, 1'b1, 1'b0, 10'd0,   20'h00000, 8'd2};
    vt[4] = '{1'b1, 1'b0, 1'b1, 10'h3FF, 20'hFFFFF, 1'b1, 1'b1, 10'h3FF, 20'hFFFFF, 8'd3};
    vt[5] = '{1'b0, 1'b1, 1'b1, 10'd1,   20'h00001, 1'b0, 1'b0, 10'd0,   20'h00000, 8'd3};

    ranks[0] = 10'd3; ranks[1] = 10'd7; ranks[2] = 10'd9;

    rst = 1'b1;
    deq_en = 1'b0;
    pifo_busy = 1'b0;
    pifo_valid_out = 1'b0;
    pifo_rank_out = '0;
    pifo_meta_out = '0;
    cli_if.enq_valid = 1'b1;
    cli_if.enq_rank = 10'd4;
    cli_if.enq_meta = 20'h4;
    cli_if.deq_ready = 1'b0;
    tick();
    tick();
    chk("rst_enq_ready", {31'b0, cli_if.enq_ready}, 32'd0);
    chk("rst_insert", {31'b0, pifo_insert}, 32'd0);
    chk("rst_rank_in", {22'b0, pifo_rank_in}, 32'd0);
    chk("rst_remove", {31'b0, pifo_remove}, 32'd0);
    rst = 1'b0;
    cli_if.enq_valid = 1'b0;
    chk("rst_occ", {24'b0, occupancy}, 32'd0);
    chk("rst_deq_valid", {31'b0, cli_if.deq_valid}, 32'd0);
    chk("rst_deq_rank", {22'b0, cli_if.deq_rank}, 32'd0);
    chk("rst_err", {31'b0, err_underflow}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      cli_if.enq_valid = vt[i].ev;
      pifo_busy        = vt[i].busy;
      pifo_valid_out   = vt[i].pvo;
      cli_if.enq_rank  = vt[i].rank;
      cli_if.enq_meta  = vt[i].meta;
      #1;
      chk($sformatf("vec%0d_ready", i), {31'b0, cli_if.enq_ready}, {31'b0, vt[i].e_ready});
      chk($sformatf("vec%0d_insert", i), {31'b0, pifo_insert}, {31'b0, vt[i].e_ins});
      chk($sformatf("vec%0d_rank_in", i), {22'b0, pifo_rank_in}, {22'b0, vt[i].e_rank});
      chk($sformatf("vec%0d_meta_in", i), {12'b0, pifo_meta_in}, {12'b0, vt[i].e_meta});
      chk($sformatf("vec%0d_remove", i), {31'b0, pifo_remove}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_occ", i), {24'b0, occupancy}, {24'b0, vt[i].e_occ});
    end
    pifo_busy = 1'b0;
    pifo_valid_out = 1'b0;

    // fill to capacity
    cli_if.enq_valid = 1'b1;
    for (int i = 0; i < 157; i++) tick();
    chk("full_occ", {24'b0, occupancy}, 32'd160);
    cli_if.enq_rank = 10'd8;
    #1;
    chk("full_ready", {31'b0, cli_if.enq_ready}, 32'd0);
    chk("full_insert", {31'b0, pifo_insert}, 32'd0);
    tick();
    chk("full_hold_occ", {24'b0, occupancy}, 32'd160);
    deq_en = 1'b1;
    pifo_valid_out = 1'b1;
    pifo_rank_out = 10'd3;
    pifo_meta_out = 20'h33;
    #1;
    chk("full_remove", {31'b0, pifo_remove}, 32'd1);
    chk("full_insert_b", {31'b0, pifo_insert}, 32'd0);
    tick();
    deq_en = 1'b0;
    pifo_valid_out = 1'b0;
    chk("after_rm_occ", {24'b0, occupancy}, 32'd159);
    #1;
    chk("held_req_ready", {31'b0, cli_if.enq_ready}, 32'd1);
    chk("held_req_insert", {31'b0, pifo_insert}, 32'd1);
    chk("held_req_rank", {22'b0, pifo_rank_in}, 32'd8);
    chk("fifo_first", {22'b0, cli_if.deq_rank}, 32'd3);
    tick();
    cli_if.enq_valid = 1'b0;
    chk("refill_occ", {24'b0, occupancy}, 32'd160);

    // reset mid-operation discards FIFO contents and occupancy
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_occ", {24'b0, occupancy}, 32'd0);
    chk("midrst_deq_valid", {31'b0, cli_if.deq_valid}, 32'd0);

    // paced removal: ranks 3,7,9 at t, t+3, t+6
    cli_if.enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cli_if.enq_valid = 1'b0;
    deq_en = 1'b1;
    cli_if.deq_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      pifo_valid_out = (k < 3);
      pifo_rank_out  = (k < 3) ? ranks[k] : 10'd0;
      pifo_meta_out  = (k < 3) ? {10'd0, ranks[k]} + 20'h100 : 20'd0;
      exp_rem = (cyc % 3 == 0) && (cyc < 9);
      exp_dv  = (cyc % 3 == 1) && (cyc < 9);
      #1;
      chk($sformatf("pace_rm_c%0d", cyc), {31'b0, pifo_remove}, {31'b0, exp_rem});
      chk($sformatf("pace_dv_c%0d", cyc), {31'b0, cli_if.deq_valid}, {31'b0, exp_dv});
      if (exp_dv) begin
        chk($sformatf("pace_rank_c%0d", cyc), {22'b0, cli_if.deq_rank}, {22'b0, ranks[(cyc-1)/3]});
        chk($sformatf("pace_meta_c%0d", cyc), {12'b0, cli_if.deq_meta}, {22'b0, ranks[(cyc-1)/3]} + 32'h100);
      end
      @(posedge clk);
      #1;
      if (exp_rem) k++;
    end
    chk("pace_occ", {24'b0, occupancy}, 32'd0);
    chk("pace_err", {31'b0, err_underflow}, 32'd0);

    // output backpressure with OUT_DEPTH=2
    deq_en = 1'b0;
    do_reset();
    cli_if.enq_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    cli_if.enq_valid = 1'b0;
    cli_if.deq_ready = 1'b0;
    deq_en = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      pifo_valid_out = 1'b1;
      pifo_rank_out  = 10'd11 + 10'(k);
      pifo_meta_out  = 20'hB0 + 20'(k);
      exp_rem = (cyc == 0) || (cyc == 3);
      #1;
      chk($sformatf("bp_rm_c%0d", cyc), {31'b0, pifo_remove}, {31'b0, exp_rem});
      @(posedge clk);
      #1;
      if (exp_rem) k++;
    end
    chk("bp_dv", {31'b0, cli_if.deq_valid}, 32'd1);
    chk("bp_head", {22'b0, cli_if.deq_rank}, 32'd11);
    pifo_rank_out = 10'd13;
    pifo_meta_out = 20'hB2;
    cli_if.deq_ready = 1'b1;
    #1;
    chk("bp_free_remove", {31'b0, pifo_remove}, 32'd1);
    chk("bp_pop_head", {22'b0, cli_if.deq_rank}, 32'd11);
    tick();
    pifo_valid_out = 1'b0;
    chk("bp_second", {22'b0, cli_if.deq_rank}, 32'd12);
    chk("bp_second_dv", {31'b0, cli_if.deq_valid}, 32'd1);
    tick();
    chk("bp_third", {22'b0, cli_if.deq_rank}, 32'd13);
    chk("bp_third_meta", {12'b0, cli_if.deq_meta}, 32'hB2);
    tick();
    chk("bp_empty", {31'b0, cli_if.deq_valid}, 32'd0);
    chk("bp_occ", {24'b0, occupancy}, 32'd2);
    cli_if.deq_ready = 1'b0;

    // underflow: remove with occupancy 0
    deq_en = 1'b0;
    do_reset();
    deq_en = 1'b1;
    pifo_valid_out = 1'b1;
    cli_if.deq_ready = 1'b1;
    #1;
    chk("uf_remove", {31'b0, pifo_remove}, 32'd1);
    tick();
    pifo_valid_out = 1'b0;
    chk("uf_occ", {24'b0, occupancy}, 32'd0);
    chk("uf_err", {31'b0, err_underflow}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("uf_err_sticky", {31'b0, err_underflow}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("uf_err_cleared", {31'b0, err_underflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
